// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the data-memory access unit: request opcodes,
// store format codes, FSM states and default address map.
package mem_access_unit_pkg;

  localparam logic [31:0] ADDR_BASE_DEFAULT   = 32'h1001_0000;
  localparam int          DEPTH_WORDS_DEFAULT = 1024;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LBU = 3'b001,
    OP_LH  = 3'b010,
    OP_LHU = 3'b011,
    OP_LW  = 3'b100,
    OP_SB  = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } mem_op_e;

  typedef enum logic [1:0] {
    FMT_WORD = 2'b00,
    FMT_HALF = 2'b01,
    FMT_BYTE = 2'b10
  } store_fmt_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_WR   = 2'b10,
    S_RESP = 2'b11
  } state_e;

  function automatic logic is_load(mem_op_e op);
    return (op <= OP_LW);
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane handling: extracts and extends load data from a word,
// and merges sub-word store data into a previously read word.
module lane_align
  import mem_access_unit_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  lane,
  input  logic [31:0] load_word,
  input  logic [31:0] store_data,
  input  logic [31:0] merge_word,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = load_word[7:0];
    case (lane)
      2'd1:    sel_byte = load_word[15:8];
      2'd2:    sel_byte = load_word[23:16];
      2'd3:    sel_byte = load_word[31:24];
      default: sel_byte = load_word[7:0];
    endcase
    sel_half = lane[1] ? load_word[31:16] : load_word[15:0];

    load_data = '0;
    case (op)
      OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_data = {24'h0, sel_byte};
      OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_data = {16'h0, sel_half};
      OP_LW:   load_data = load_word;
      default: load_data = '0;
    endcase
  end

  // Only the addressed lane(s) are replaced; word stores pass straight through.
  always_comb begin
    merged_word = merge_word;
    case (op)
      OP_SB: begin
        case (lane)
          2'd1:    merged_word[15:8]  = store_data[7:0];
          2'd2:    merged_word[23:16] = store_data[7:0];
          2'd3:    merged_word[31:24] = store_data[7:0];
          default: merged_word[7:0]   = store_data[7:0];
        endcase
      end
      OP_SH: begin
        if (lane[1]) merged_word[31:16] = store_data[15:0];
        else         merged_word[15:0]  = store_data[15:0];
      end
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit in front of a word-addressed data memory,
// with sub-word loads, direct stores and read-modify-write for unaligned lanes.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT,
  parameter int          DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dm_r,
  output logic        dm_w,
  output logic [1:0]  store_format_signal,
  output logic [10:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  localparam logic [31:0] BYTE_LIMIT = 32'(4 * DEPTH_WORDS);

  state_e      state, state_nxt;
  mem_op_e     op_q;
  logic [10:0] idx_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic        load_q;
  logic        rmw_q;
  store_fmt_e  fmt;

  mem_op_e     op_in;
  logic [31:0] off;
  logic [1:0]  lane_in;
  logic        err_in;
  logic        load_in;
  logic        rmw_in;
  logic        accept;

  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign op_in   = mem_op_e'(req_op);
  assign off     = req_addr - ADDR_BASE;
  assign lane_in = off[1:0];
  assign load_in = is_load(op_in);

  // Addresses below the base wrap to huge offsets, so one unsigned compare covers both ends.
  assign err_in = (off >= BYTE_LIMIT)
               || ((op_in == OP_LH || op_in == OP_LHU || op_in == OP_SH) && lane_in[0])
               || ((op_in == OP_LW || op_in == OP_SW) && (lane_in != 2'd0));

  assign rmw_in = ((op_in == OP_SB) && (lane_in != 2'd0))
               || ((op_in == OP_SH) && (lane_in == 2'd2));

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign accept     = req_ready && req_valid;
  assign store_format_signal = fmt;

  lane_align u_lane_align (
    .op          (op_q),
    .lane        (lane_q),
    .load_word   (dm_rdata),
    .store_data  (wdata_q),
    .merge_word  (word_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    state_nxt = state;
    dm_r      = 1'b0;
    dm_w      = 1'b0;
    fmt       = FMT_WORD;
    dm_addr   = '0;
    dm_wdata  = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (err_in)                 state_nxt = S_RESP;
          else if (load_in || rmw_in) state_nxt = S_RD;
          else                        state_nxt = S_WR;
        end
      end
      S_RD: begin
        dm_r      = 1'b1;
        dm_addr   = idx_q;
        state_nxt = load_q ? S_RESP : S_WR;
      end
      S_WR: begin
        dm_w      = 1'b1;
        dm_addr   = idx_q;
        if (rmw_q) begin
          dm_wdata = merged_word;
          fmt      = FMT_WORD;
        end else begin
          dm_wdata = wdata_q;
          case (op_q)
            OP_SB:   fmt = FMT_BYTE;
            OP_SH:   fmt = FMT_HALF;
            default: fmt = FMT_WORD;
          endcase
        end
        state_nxt = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The response registers are loaded at acceptance (error/store) or at the end of RD (load).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= OP_LB;
      idx_q      <= '0;
      lane_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
      load_q     <= 1'b0;
      rmw_q      <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q       <= op_in;
        idx_q      <= off[12:2];
        lane_q     <= lane_in;
        wdata_q    <= req_wdata;
        load_q     <= load_in;
        rmw_q      <= rmw_in;
        resp_err   <= err_in;
        resp_rdata <= '0;
      end
      if (state == S_RD) begin
        word_q <= dm_rdata;
        if (load_q) resp_rdata <= load_data;
      end
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: ADDR_BASE, 32'h1001_0000, byte address that maps to data-memory word 0.
REQ-002 Parameter: DEPTH_WORDS, 1024, number of words in the attached data memory.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 req_valid  in  1  request present; req_ready  out  1  unit can accept a request.
REQ-006 req_op  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
REQ-007 req_addr  in  32  byte address; req_wdata  in  32  store data, right-aligned.
REQ-008 resp_valid  out  1; resp_ready  in  1; resp_rdata  out  32  extended load data; resp_err  out  1  misaligned or out-of-range.
REQ-009 dm_r  out  1; dm_w  out  1; store_format_signal  out  2  (00 word, 01 low half, 10 low byte); dm_addr  out  11  word index.
REQ-010 dm_wdata  out  32; dm_rdata  in  32  combinational read data, valid in the same cycle as dm_r.

Function
REQ-011 The unit SHALL be an FSM with states IDLE, RD, WR and RESP, and SHALL accept one request at a time.
REQ-012 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready on a posedge, and its fields are registered at that edge.
REQ-013 off = req_addr - ADDR_BASE; word index = off[12:2]; lane = off[1:0].
REQ-014 An error SHALL be flagged for off >= 4*DEPTH_WORDS (unsigned), or for LH/LHU/SH with lane[0]=1, or for LW/SW with lane!=0.
REQ-015 An erroring request SHALL go IDLE->RESP with resp_err=1 and resp_rdata=0, and SHALL assert neither dm_r nor dm_w.
REQ-016 A load SHALL go IDLE->RD->RESP: dm_r=1 in RD, and dm_rdata SHALL be captured at the end of RD.
REQ-017 The load result SHALL be the selected byte (lane) or halfword (lane[1]) of the captured word: sign-extended for LB/LH, zero-extended for LBU/LHU, and the whole word for LW.
REQ-018 SW, and SB/SH with lane=0, SHALL go IDLE->WR->RESP with dm_w=1 for one cycle, format 00/10/01 respectively, and dm_wdata=req_wdata.
REQ-019 SB with lane!=0 and SH with lane=2 SHALL perform a read-modify-write, IDLE->RD->WR->RESP.
REQ-020 In the read-modify-write, the word read in RD SHALL have only the target lane(s) replaced, and WR SHALL write the merged word with format 00.
REQ-021 dm_addr SHALL hold the word index throughout RD and WR; dm_r, dm_w and the format SHALL be 0 in all other states.
REQ-022 dm_r and dm_w SHALL never be asserted in the same cycle.
REQ-023 resp_valid SHALL be 1 in RESP, with resp_rdata and resp_err held stable.
REQ-024 The FSM SHALL stay in RESP until resp_ready=1, then return to IDLE; no request is accepted in that return cycle.
REQ-025 Latency from the acceptance edge to resp_valid, with resp_ready held at 1: error 1 cycle; load or direct store 2 cycles; read-modify-write 3 cycles.
REQ-026 For stores, resp_rdata SHALL be 0.

Reset
REQ-027 When rst_n=0 at a posedge, the FSM SHALL enter IDLE, and resp_valid, resp_err, resp_rdata, dm_r, dm_w, store_format_signal, dm_addr and dm_wdata SHALL all be 0.
REQ-028 A reset in the middle of an operation SHALL abort it without issuing any further dm_w pulse, and the aborted request SHALL receive no response.
REQ-029 req_ready SHALL read 1 in the first cycle after rst_n returns to 1.

Structure
REQ-030 A shared package SHALL hold the req_op encodings, the store_format codes, the FSM state enum and the ADDR_BASE default.
REQ-031 Lane extraction/extension and lane merge SHALL be in one combinational sub-module, lane_align; the FSM and registers stay in mem_access_unit.

Verification
REQ-032 Preload word 0 = 32'h80FF_7F01; LB at 32'h1001_0003 -> resp_rdata=32'hFFFF_FF80 two cycles after acceptance; LBU at the same address -> 32'h0000_0080.
REQ-033 LH at 32'h1001_0002 on word 32'h80FF_7F01 -> 32'hFFFF_80FF; LHU at 32'h1001_0000 -> 32'h0000_7F01.
REQ-034 SB with data 32'hAB at 32'h1001_0005 over word 1 = 32'h1122_3344 -> RD, then a WR with format 00 writing 32'h1122_AB44; resp_valid after 3 cycles.
REQ-035 LW at 32'h1001_0002, and SW at 32'h1001_1000 -> resp_err=1 after 1 cycle, and dm_r/dm_w never asserted.
REQ-036 Hold resp_ready=0 for 5 cycles during a load -> resp_valid and resp_rdata stable and req_ready=0 throughout; 1 cycle after resp_ready=1 the unit is back in IDLE.
REQ-037 Drive rst_n=0 during the RD of a read-modify-write -> no dm_w pulse, all outputs 0, and req_ready=1 one cycle after rst_n returns to 1.
